// File: rtl/alu_arbiter_if.sv
// Request/response channels between the two issuing units and alu_arbiter.
//
// Handshake semantics (all four channels): a transfer happens on a rising
// clock edge where both valid and ready are high. The source keeps its
// payload stable while valid is high and ready is low; the sink may raise
// ready only combinationally from its own state, never from a future edge.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single combinational ALU. Round-robin
// arbitration in IDLE, one EXEC cycle to capture the ALU result, then RESP
// holds the result for the owning requester until it is taken.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy,
  output logic [CNTW-1:0]  done0_cnt,
  output logic [CNTW-1:0]  done1_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic             r_prio;     // requester favoured on a tie
  logic             r_owner;    // requester whose op is in flight
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [CNTW-1:0]  r_done0;
  logic [CNTW-1:0]  r_done1;

  logic             w_grant;    // requester selected this IDLE cycle
  logic             w_accept;   // a request is taken on the coming edge
  logic             w_rsp_done; // owner takes the result on the coming edge

  // Arbitration, handshake outputs and next state; ready/valid are gated by
  // reset so nothing is offered or accepted while reset is asserted.
  always_comb begin
    w_next_state   = r_state;
    w_grant        = 1'b0;
    w_accept       = 1'b0;
    w_rsp_done     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) w_grant = r_prio;
        else                                  w_grant = bus.req1_valid;
        w_accept       = (bus.req0_valid || bus.req1_valid) && !reset;
        bus.req0_ready = w_accept && !w_grant;
        bus.req1_ready = w_accept && w_grant;
        if (w_accept) w_next_state = S_EXEC;
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        bus.rsp0_valid = !reset && !r_owner;
        bus.rsp1_valid = !reset && r_owner;
        w_rsp_done     = !reset && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);
        if (w_rsp_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, ownership and round-robin priority
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept)   r_owner <= w_grant;
      if (w_rsp_done) r_prio  <= ~r_owner;
    end
  end

  // Operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_grant ? bus.req1_a  : bus.req0_a;
        r_b  <= w_grant ? bus.req1_b  : bus.req0_b;
        r_op <= w_grant ? bus.req1_op : bus.req0_op;
      end
      if (r_state == S_EXEC) r_result <= alu_c;
    end
  end

  // Saturating per-requester completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done0 <= '0;
      r_done1 <= '0;
    end else if (w_rsp_done) begin
      if (!r_owner && r_done0 != CNT_MAX) r_done0 <= r_done0 + CNT_ONE;
      if (r_owner  && r_done1 != CNT_MAX) r_done1 <= r_done1 + CNT_ONE;
    end
  end

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign bus.rsp_data = r_result;
  assign busy         = (r_state != S_IDLE);
  assign done0_cnt    = r_done0;
  assign done1_cnt    = r_done1;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with hand-computed results, a
// per-requester expected queue and a negedge monitor that checks each
// completed response. Built with CNTW=4 so counter saturation is reachable.
module tb_alu_arbiter;

  localparam int W    = 32;
  localparam int CNTW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  logic [W-1:0]    alu_a, alu_b, alu_c;
  logic [3:0]      alu_op;
  logic            busy;
  logic [CNTW-1:0] done0_cnt, done1_cnt;
  logic [1:0]      dbg_state;

  alu_arbiter #(.WIDTH(W), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt),
    .dbg_state(dbg_state)
  );

  // External ALU seen by the arbiter
  always_comb begin
    case (alu_op)
      4'b0000: alu_c = alu_a + alu_b;
      4'b0001: alu_c = alu_a - alu_b;
      4'b0010: alu_c = alu_a | alu_b;
      default: alu_c = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int           grant_log[$];
  int           grant_cyc[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: every completed response is compared against its owner's queue
  always @(negedge clk) begin
    if (bus.rsp0_valid && bus.rsp1_valid) fail("rsp_both_valid");
    if (bus.rsp0_valid && bus.rsp0_ready) begin
      if (exp0_q.size() == 0) fail("rsp0_unexpected");
      else check("rsp0_data", bus.rsp_data, exp0_q.pop_front());
    end
    if (bus.rsp1_valid && bus.rsp1_ready) begin
      if (exp1_q.size() == 0) fail("rsp1_unexpected");
      else check("rsp1_data", bus.rsp_data, exp1_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Raise valid, wait (bounded) for ready, drop valid after the accepting edge
  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input logic [W-1:0] exp);
    bit got;
    got = 1'b0;
    if (n == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
      exp0_q.push_back(exp);
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
      exp1_q.push_back(exp);
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (got) begin
      grant_log.push_back(n);
      grant_cyc.push_back(cyc);
    end else begin
      fail(n == 0 ? "issue0_timeout" : "issue1_timeout");
    end
    tick();
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp0_q.size() == 0 && exp1_q.size() == 0;
    end
    if (!ok) fail("wait_idle_timeout");
    tick();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    // Reset values
    reset_dut();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_cnt0", done0_cnt, 0);
    check("rst_cnt1", done1_cnt, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_alu_a", alu_a, 0);

    // Latency: add 5+7, ready at T, rsp0_valid at T+2
    tick();
    bus.req0_a = 5; bus.req0_b = 7; bus.req0_op = 4'b0000; bus.req0_valid = 1'b1;
    exp0_q.push_back(32'd12);
    @(negedge clk);
    check("lat_ready0_T", bus.req0_ready, 1);
    check("lat_ready1_T", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("lat_rsp0_T1", bus.rsp0_valid, 0);
    check("lat_busy_T1", busy, 1);
    @(negedge clk);
    check("lat_rsp0_T2", bus.rsp0_valid, 1);
    tick();
    @(negedge clk);
    check("lat_cnt0", done0_cnt, 1);
    check("lat_idle", busy, 0);

    // Sub wrap and or
    tick();
    issue(1, 32'd3, 32'd5, 4'b0001, 32'hFFFF_FFFE);
    wait_idle();
    issue(0, 32'hF0, 32'h0F, 4'b0010, 32'hFF);
    wait_idle();
    check("ops_cnt0", done0_cnt, 2);
    check("ops_cnt1", done1_cnt, 1);

    // Both valid continuously: grants alternate 0,1,0,1 three cycles apart
    reset_dut();
    grant_log.delete();
    grant_cyc.delete();
    fork
      begin
        issue(0, 32'd100, 32'd1, 4'b0000, 32'd101);
        issue(0, 32'd200, 32'd2, 4'b0000, 32'd202);
      end
      begin
        issue(1, 32'd10, 32'd3, 4'b0001, 32'd7);
        issue(1, 32'h30, 32'h05, 4'b0010, 32'h35);
      end
    join
    wait_idle();
    if (grant_log.size() != 4) fail("rr_grant_count");
    else begin
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 1);
      check("rr_g2", grant_log[2], 0);
      check("rr_g3", grant_log[3], 1);
      for (int i = 1; i < 4; i++) check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    check("rr_cnt0", done0_cnt, 2);
    check("rr_cnt1", done1_cnt, 2);

    // Back-pressure on rsp0 while req1 waits
    bus.rsp0_ready = 1'b0;
    bus.req0_a = 1; bus.req0_b = 1; bus.req0_op = 4'b0000; bus.req0_valid = 1'b1;
    exp0_q.push_back(32'd2);
    @(negedge clk);
    check("bp_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_a = 9; bus.req1_b = 4; bus.req1_op = 4'b0001; bus.req1_valid = 1'b1;
    exp1_q.push_back(32'd5);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp0_valid", bus.rsp0_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 32'd2);
      check("bp_ready1", bus.req1_ready, 0);
    end
    tick();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("bp_req1_granted", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    wait_idle();
    check("bp_cnt0", done0_cnt, 3);
    check("bp_cnt1", done1_cnt, 3);

    // Unknown op code returns 0 and still counts
    issue(1, 32'd9, 32'd9, 4'b1111, 32'd0);
    wait_idle();
    check("op_f_cnt1", done1_cnt, 4);

    // Counter saturation with 17 ops on requester 0
    reset_dut();
    for (int i = 0; i < 17; i++) issue(0, i, 32'd0, 4'b0000, i);
    wait_idle();
    check("sat_cnt0", done0_cnt, 15);
    check("sat_cnt1", done1_cnt, 0);

    // Reset during EXEC (prio first moved to requester 1)
    issue(0, 32'd1, 32'd2, 4'b0000, 32'd3);
    wait_idle();
    bus.req0_a = 4; bus.req0_b = 4; bus.req0_op = 4'b0000; bus.req0_valid = 1'b1;
    @(negedge clk);
    check("rx_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rx_state", dbg_state, 0);
    check("rx_cnt0", done0_cnt, 0);
    @(negedge clk);
    check("rx_no_rsp", bus.rsp0_valid, 0);

    // Reset during RESP
    tick();
    issue(0, 32'd1, 32'd1, 4'b0000, 32'd2);
    wait_idle();
    bus.rsp1_ready = 1'b0;
    bus.req1_a = 6; bus.req1_b = 6; bus.req1_op = 4'b0000; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rr_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rr_in_resp", bus.rsp1_valid, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rr_valid_in_rst", bus.rsp1_valid, 0);
    tick();
    reset = 1'b0;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check("rr_state", dbg_state, 0);
    check("rr_no_rsp", bus.rsp1_valid, 0);
    check("rr_cnt0", done0_cnt, 0);
    check("rr_cnt1", done1_cnt, 0);

    // Priority back to requester 0 after reset
    tick();
    bus.req0_a = 4; bus.req0_b = 4; bus.req0_op = 4'b0000; bus.req0_valid = 1'b1;
    bus.req1_a = 1; bus.req1_b = 1; bus.req1_op = 4'b0000; bus.req1_valid = 1'b1;
    exp0_q.push_back(32'd8);
    @(negedge clk);
    check("prio_ready0", bus.req0_ready, 1);
    check("prio_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle();

    check("final_q0_empty", exp0_q.size(), 0);
    check("final_q1_empty", exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
